capture_glyph: RTL and testbench

CAPTURE_GLYPH -- requirements
Module: capture_glyph

---
 rtl/capture_glyph_pkg.sv | 7 +
 rtl/capture_glyph_rd_lat_pipe.sv | 16 +
 rtl/capture_glyph.sv | 120 ++++++++++++
 tb/tb_capture_glyph.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/capture_glyph_pkg.sv
// capture_glyph_pkg: shared constants and sizing helpers for the glyph capture block.
package capture_glyph_pkg;
  localparam int unsigned MAX_RD_LAT = 4;
  function automatic int unsigned cnt_bits(input int unsigned n);
    return $clog2(n + 1);
  endfunction
endpackage

// File: rtl/capture_glyph_rd_lat_pipe.sv
// rd_lat_pipe: RD_LAT-deep valid shift register marking when a read's pixel returns.
module rd_lat_pipe #(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_valid
);
  logic [RD_LAT-1:0] r_pipe;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_pipe <= '0;
    else     r_pipe <= RD_LAT'({r_pipe, i_valid});
  end
  assign o_valid = r_pipe[RD_LAT-1];
endmodule

// File: rtl/capture_glyph.sv
// capture_glyph: reads one WIDTH x HEIGHT glyph cell from a latency-RD_LAT framebuffer
// and emits it as packed lines.
module capture_glyph
  import capture_glyph_pkg::*;
#(
  parameter int CORDW  = 16,
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 16,
  parameter int RD_LAT = 2,
  parameter int LSB    = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        oe,
  input  logic signed [CORDW-1:0]     cx,
  input  logic signed [CORDW-1:0]     cy,
  output logic signed [CORDW-1:0]     x,
  output logic signed [CORDW-1:0]     y,
  output logic                        rd_req,
  input  logic                        rd_pix,
  output logic [WIDTH-1:0]            glyph_line,
  output logic [$clog2(HEIGHT)-1:0]   line_id,
  output logic                        line_valid,
  output logic                        busy,
  output logic                        done
);
  localparam int CW = cnt_bits(WIDTH);
  localparam int IW = $clog2(WIDTH);
  localparam int LW = $clog2(HEIGHT);
  typedef enum logic [2:0] {IDLE, START, REQ, DRAIN, LINE, DONE} state_t;
  state_t r_state, w_next;
  logic signed [CORDW-1:0] r_x, r_y, r_cx0;
  logic [CW-1:0] r_req_cnt, r_ret_cnt;
  logic [WIDTH-1:0] r_work, r_glyph, w_work_nxt;
  logic [LW-1:0] r_line_id;
  logic r_busy;
  logic w_ret_vld, w_req_last, w_ret_last, w_line_last;
  logic [IW-1:0] w_bit;
  rd_lat_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk     (clk),
    .rst     (rst),
    .i_valid (rd_req),
    .o_valid (w_ret_vld)
  );
  always_comb begin
    w_req_last  = r_req_cnt == CW'(WIDTH - 1);
    w_ret_last  = w_ret_vld && (r_ret_cnt == CW'(WIDTH - 1));
    w_line_last = r_line_id == LW'(HEIGHT - 1);
    w_bit       = (LSB != 0) ? r_ret_cnt[IW-1:0] : IW'(WIDTH - 1) - r_ret_cnt[IW-1:0];
    w_work_nxt  = r_work;
    w_work_nxt[w_bit] = rd_pix;
    w_next = r_state;
    unique case (r_state)
      IDLE:    w_next = start ? START : IDLE;
      START:   w_next = REQ;
      REQ:     w_next = (oe && w_req_last) ? DRAIN : REQ;
      DRAIN:   w_next = w_ret_last ? LINE : DRAIN;
      LINE:    w_next = w_line_last ? DONE : REQ;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end
  // The completed line is published on the final capture so it is already stable during LINE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x       <= '0;
      r_y       <= '0;
      r_cx0     <= '0;
      r_req_cnt <= '0;
      r_ret_cnt <= '0;
      r_work    <= '0;
      r_glyph   <= '0;
      r_line_id <= '0;
      r_busy    <= 1'b0;
    end else begin
      if (w_ret_vld) begin
        r_work    <= w_work_nxt;
        r_ret_cnt <= r_ret_cnt + CW'(1);
      end
      if (w_ret_last) r_glyph <= w_work_nxt;
      unique case (r_state)
        START: begin
          r_cx0     <= cx;
          r_x       <= cx;
          r_y       <= cy;
          r_line_id <= '0;
          r_busy    <= 1'b1;
          r_req_cnt <= '0;
          r_ret_cnt <= '0;
        end
        REQ: if (oe) begin
          r_req_cnt <= r_req_cnt + CW'(1);
          if (!w_req_last) r_x <= r_x + CORDW'(1);
        end
        LINE: if (!w_line_last) begin
          r_line_id <= r_line_id + LW'(1);
          r_y       <= r_y + CORDW'(1);
          r_x       <= r_cx0;
          r_req_cnt <= '0;
          r_ret_cnt <= '0;
        end
        DONE:    r_busy <= 1'b0;
        default: ;
      endcase
    end
  end
  assign x          = r_x;
  assign y          = r_y;
  assign rd_req     = (r_state == REQ) && oe;
  assign glyph_line = r_glyph;
  assign line_id    = r_line_id;
  assign line_valid = r_state == LINE;
  assign busy       = r_busy;
  assign done       = r_state == DONE;
endmodule

// File: tb/tb_capture_glyph.sv
// tb_capture_glyph: directed checks of capture_glyph (LSB=0 and LSB=1 instances) against
// a latency-2 framebuffer model.
module tb_capture_glyph;
  localparam int RDL = 2;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, oe = 1'b1;
  logic rd_pix;
  logic signed [15:0] cx = 16'sd0, cy = 16'sd0;
  logic signed [15:0] x, y, x1, y1;
  logic rd_req, rd_req1, line_valid, lv1, busy, busy1, done, done1;
  logic [7:0] glyph_line, glyph1;
  logic [3:0] line_id, line_id1;
  int checks = 0, errors = 0;
  logic signed [15:0] ox = 16'sd0, oy = 16'sd0, last_y;
  int mode = 0;
  int n_lv, n_req, n_done, first_lv, last_lv, done_cyc, line, ridx;
  logic [7:0] g0, g0b;
  logic pv [RDL];
  logic signed [15:0] px [RDL];
  logic signed [15:0] py [RDL];

  capture_glyph #(.CORDW(16), .WIDTH(8), .HEIGHT(16), .RD_LAT(RDL), .LSB(0)) u_dut (
    .clk(clk), .rst(rst), .start(start), .oe(oe), .cx(cx), .cy(cy), .x(x), .y(y),
    .rd_req(rd_req), .rd_pix(rd_pix), .glyph_line(glyph_line), .line_id(line_id),
    .line_valid(line_valid), .busy(busy), .done(done));
  capture_glyph #(.CORDW(16), .WIDTH(8), .HEIGHT(16), .RD_LAT(RDL), .LSB(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .oe(oe), .cx(cx), .cy(cy), .x(x1), .y(y1),
    .rd_req(rd_req1), .rd_pix(rd_pix), .glyph_line(glyph1), .line_id(line_id1),
    .line_valid(lv1), .busy(busy1), .done(done1));

  always #5 clk = ~clk;

  function automatic logic pix(input int rx, input int ry, input int m);
    return (m == 0) ? (((rx + ry) & 1) == 0) : (((rx + 2 * ry) % 3) == 0);
  endfunction

  function automatic logic [7:0] exp_line(input int ry, input int lsb, input int m);
    logic [7:0] r;
    r = '0;
    for (int rx = 0; rx < 8; rx++) r[(lsb != 0) ? rx : 7 - rx] = pix(rx, ry, m);
    return r;
  endfunction

  always @(posedge clk) begin
    pv[0] <= rd_req;
    px[0] <= x;
    py[0] <= y;
    for (int i = 1; i < RDL; i++) begin
      pv[i] <= pv[i-1];
      px[i] <= px[i-1];
      py[i] <= py[i-1];
    end
  end
  assign rd_pix = pv[RDL-1] & pix(int'(px[RDL-1] - ox), int'(py[RDL-1] - oy), mode);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic capture(input logic signed [15:0] cx_i, input logic signed [15:0] cy_i,
                         input int m, input int oe_off, input int rst_at, input int st2,
                         input int ncyc);
    ox = cx_i; oy = cy_i; mode = m;
    n_lv = 0; n_req = 0; n_done = 0; first_lv = -1; last_lv = -1; done_cyc = -1;
    line = 0; ridx = 0; last_y = '0; g0 = '0; g0b = '0;
    for (int c = 0; c < ncyc; c++) begin
      start = (c == 0) || (c == st2);
      cx = (c >= st2 && c < st2 + 10) ? 16'sd99 : cx_i;
      cy = (c >= st2 && c < st2 + 10) ? 16'sd99 : cy_i;
      oe = !(c >= oe_off && c < oe_off + 3);
      if (c == rst_at + 2) rst = 1'b0;
      #1;
      if (c == rst_at) begin
        chk("pre_rst_state", {60'd0, rd_req, busy, line_valid, done}, 64'b0100);
        chk("pre_rst_lines", 64'(n_lv), 64'd5);
        rst = 1'b1;
        #1;
        chk("rst_outputs", {x, y, rd_req, glyph_line, line_id, line_valid, busy, done}, 64'd0);
      end
      if (rd_req) begin
        chk("req_xy", {rd_req1, x, y, x1, y1},
            {1'b1, ox + 16'(ridx), oy + 16'(line), ox + 16'(ridx), oy + 16'(line)});
        ridx++;
        n_req++;
      end
      if (line_valid) begin
        chk("line_meta", {line_id, y, busy, lv1, line_id1, 4'(ridx)},
            {4'(line), oy + 16'(line), 1'b1, 1'b1, 4'(line), 4'd8});
        chk("glyph", {glyph_line, glyph1}, {exp_line(line, 0, mode), exp_line(line, 1, mode)});
        if (line == 0) begin g0 = glyph_line; g0b = glyph1; end
        if (first_lv < 0) first_lv = c;
        last_lv = c;
        last_y = y;
        n_lv++;
        line++;
        ridx = 0;
      end
      if (done) begin
        chk("done1", 64'(done1), 64'd1);
        n_done++;
        done_cyc = c;
      end
      @(negedge clk);
    end
    start = 1'b0;
    oe = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    chk("reset_outputs", {x, y, rd_req, glyph_line, line_id, line_valid, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    chk("idle_after_reset", {60'd0, rd_req, line_valid, busy, done}, 64'd0);

    // Checkerboard cell at (10,20) with a stray start pulse mid-capture.
    capture(16'sd10, 16'sd20, 0, -100, -100, 50, 185);
    chk("t1_first_lv", 64'(first_lv), 64'd12);
    chk("t1_last_lv", 64'(last_lv), 64'd177);
    chk("t1_done_cyc", 64'(done_cyc), 64'd178);
    chk("t1_counts", {32'(n_lv), 16'(n_req), 16'(n_done)}, {32'd16, 16'd128, 16'd1});
    chk("t1_row0", {g0, g0b}, 64'hAA55);
    chk("t1_last_y", 64'(last_y), 64'(16'sd35));
    chk("t1_idle_busy", {busy, busy1}, 64'd0);

    // Pattern cell at (0,0) with oe dropped for cycles 5..7 of line 0.
    capture(16'sd0, 16'sd0, 1, 5, -100, -100, 190);
    chk("t2_first_lv", 64'(first_lv), 64'd15);
    chk("t2_last_lv", 64'(last_lv), 64'd180);
    chk("t2_done_cyc", 64'(done_cyc), 64'd181);
    chk("t2_counts", {32'(n_lv), 16'(n_req), 16'(n_done)}, {32'd16, 16'd128, 16'd1});

    // Reset during DRAIN of line 5 (cycle 65), then silence.
    capture(16'sd100, 16'sd200, 0, -100, 65, -100, 100);
    chk("t3_counts", {32'(n_lv), 16'(n_req), 16'(n_done)}, {32'd5, 16'd48, 16'd0});
    chk("t3_quiet", {60'd0, rd_req, line_valid, busy, done}, 64'd0);

    // Negative origin: fresh capture after the abort.
    capture(-16'sd4, -16'sd1, 0, -100, -100, -100, 185);
    chk("t4_first_lv", 64'(first_lv), 64'd12);
    chk("t4_done_cyc", 64'(done_cyc), 64'd178);
    chk("t4_counts", {32'(n_lv), 16'(n_req), 16'(n_done)}, {32'd16, 16'd128, 16'd1});
    chk("t4_last_y", 64'(last_y), 64'(16'sd14));
    chk("t4_row0", {g0, g0b}, 64'hAA55);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
